// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data wins taken while a fetch was waiting.
module starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAXV)) begin
      count <= count + CW'(1);
    end
  end

  assign at_max = (count == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory array between fetch (IF) and load/store (D);
// one transaction in flight, data-first priority with a fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned LW = clog2(MEM_LAT + 1);

  state_t        state, state_nx;
  owner_t        owner;
  logic          txn_we;
  logic          drop, drop_nx;
  logic          starve_at_max;
  logic          grant_win;
  logic [LW-1:0] lat_cnt;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (d_gnt && if_req),
    .clr    (if_gnt),
    .at_max (starve_at_max)
  );

  always_comb begin
    grant_win = (state == IDLE) || (state == RESP);
    if_gnt    = grant_win && if_req && (!d_req || starve_at_max);
    d_gnt     = grant_win && d_req && !(if_req && starve_at_max);

    // WAIT spans MEM_LAT cycles; its last cycle is the one mem_rdata is valid in.
    state_nx = state;
    case (state)
      IDLE:    if (if_gnt || d_gnt) state_nx = ACCESS;
      ACCESS:  state_nx = WAIT;
      WAIT:    if (lat_cnt == '0) state_nx = RESP;
      RESP:    state_nx = (if_gnt || d_gnt) ? ACCESS : IDLE;
      default: state_nx = IDLE;
    endcase

    // A new grant always starts clean, so a flush in the grant cycle hits only the old fetch.
    drop_nx = drop;
    if (if_gnt || d_gnt || (state == RESP) || (state == IDLE)) begin
      drop_nx = 1'b0;
    end else if (flush && (owner == OWN_IF)) begin
      drop_nx = 1'b1;
    end

    if_rvalid = (state == RESP) && (owner == OWN_IF) && !drop && !flush;
    d_rvalid  = (state == RESP) && (owner == OWN_D);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      txn_we    <= 1'b0;
      drop      <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state  <= state_nx;
      drop   <= drop_nx;
      mem_en <= if_gnt || d_gnt;
      mem_we <= d_gnt && d_we;

      if (d_gnt) begin
        owner     <= OWN_D;
        txn_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (if_gnt) begin
        owner    <= OWN_IF;
        txn_we   <= 1'b0;
        mem_addr <= if_addr;
      end

      if (state == ACCESS) begin
        lat_cnt <= LW'(MEM_LAT - 1);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LW'(1);
      end

      if ((state == WAIT) && (lat_cnt == '0)) begin
        if ((owner == OWN_IF) && !drop && !flush) if_rdata <= mem_rdata;
        if ((owner == OWN_D) && !txn_we) d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=3.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [30:0]   inst;
    logic          port_d;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst       [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [DW-1:0] d_rdata   [2];
  logic          flush     [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  exp_t        sbq[$];
  logic [DW-1:0] last_d = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dflt_word(input logic [AW-1:0] a);
    return (a == 10'd5) ? 32'h2842000A : (32'h10000000 + {22'd0, a});
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem  [1024];
    logic [1023:0] wr_mask = '0;
    logic [DW-1:0] pipe [L];

    always @(posedge clk) begin
      if (mem_en[g]) begin
        pipe[0] <= wr_mask[mem_addr[g]] ? mem[mem_addr[g]] : dflt_word(mem_addr[g]);
        if (mem_we[g]) begin
          mem[mem_addr[g]]     <= mem_wdata[g];
          wr_mask[mem_addr[g]] <= 1'b1;
        end
      end
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_gnt    (if_gnt[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .flush     (flush[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic port_d, input logic [DW-1:0] data);
    exp_t e;
    e.inst   = 31'(k);
    e.port_d = port_d;
    e.data   = data;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if ((if_rvalid[k] === 1'b1) || (d_rvalid[k] === 1'b1)) begin
        chk("rvalid_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("response", {31'(k), d_rvalid[k], (d_rvalid[k] ? d_rdata[k] : if_rdata[k])},
              {e.inst, e.port_d, e.data});
        end
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    sb_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sbq.size() != 0; c++) begin
      smp();
      adv();
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic [9:0] pattern;
    int unsigned ngr, nrv;
    logic gd, gi;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; flush[k] = 1'b0;
    end
    repeat (2) adv();
    smp();
    for (int k = 0; k < 2; k++) begin
      chk("reset_flags", 64'({busy[k], mem_en[k], mem_we[k], if_rvalid[k], d_rvalid[k], if_gnt[k], d_gnt[k]}), 64'd0);
      chk("reset_regs", {if_rdata[k], d_rdata[k]}, 64'd0);
    end
    adv();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // fetch timing, MEM_LAT=1
    if_req[0] = 1'b1; if_addr[0] = 10'd5;
    smp(); chk("t1_if_gnt", 64'(if_gnt[0]), 64'd1); chk("t1_busy_c0", 64'(busy[0]), 64'd0);
    push(0, 1'b0, 32'h2842000A); adv(); if_req[0] = 1'b0;
    smp(); chk("t1_mem_c1", 64'({mem_en[0], mem_we[0], mem_addr[0]}), 64'({1'b1, 1'b0, 10'd5}));
    chk("t1_busy_c1", 64'(busy[0]), 64'd1); adv();
    smp(); chk("t1_c2", 64'({busy[0], mem_en[0], if_rvalid[0]}), 64'b100); adv();
    smp(); chk("t1_c3", 64'({busy[0], if_rvalid[0]}), 64'b11); adv();
    smp(); chk("t1_busy_c4", 64'(busy[0]), 64'd0); adv();

    // simultaneous requests: data first, fetch granted back-to-back in RESP
    if_req[0] = 1'b1; if_addr[0] = 10'd9; d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 10'd7;
    smp(); chk("t2_gnt_c0", 64'({if_gnt[0], d_gnt[0]}), 64'b01);
    last_d = dflt_word(10'd7); push(0, 1'b1, last_d); adv(); d_req[0] = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      smp(); chk("t2_no_if_gnt", 64'(if_gnt[0]), 64'd0); adv();
    end
    smp(); chk("t2_c3", 64'({d_rvalid[0], if_gnt[0], busy[0]}), 64'b111);
    push(0, 1'b0, dflt_word(10'd9)); adv(); if_req[0] = 1'b0;
    smp(); chk("t2_busy_b2b", 64'(busy[0]), 64'd1); adv();
    smp(); adv();
    smp(); chk("t2_if_rvalid_c6", 64'(if_rvalid[0]), 64'd1); adv();

    // starvation guard: both held, expect d d d d i d d d d i
    if_req[0] = 1'b1; if_addr[0] = 10'd11; d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 10'd32;
    pattern = '0; ngr = 0;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      smp();
      chk("t3_one_gnt", 64'(if_gnt[0] && d_gnt[0]), 64'd0);
      gd = d_gnt[0]; gi = if_gnt[0];
      if (gd) begin
        last_d = dflt_word(d_addr[0]); push(0, 1'b1, last_d);
        pattern = {pattern[8:0], 1'b0}; ngr++;
      end else if (gi) begin
        push(0, 1'b0, dflt_word(if_addr[0]));
        pattern = {pattern[8:0], 1'b1}; ngr++;
      end
      adv();
      if (gd) d_addr[0] = d_addr[0] + 10'd1;
      if (gi) if_addr[0] = if_addr[0] + 10'd1;
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("t3_grant_count", 64'(ngr), 64'd10);
    chk("t3_grant_order", 64'(pattern), 64'(10'b0000100001));
    wait_drain(20);

    // store to top word, then load it back
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'h3FF; d_wdata[0] = 32'hDEADBEEF;
    smp(); chk("t4_d_gnt", 64'(d_gnt[0]), 64'd1); push(0, 1'b1, last_d); adv();
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    smp(); chk("t4_mem_write", 64'({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]}),
               64'({1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF})); adv();
    smp(); chk("t4_we_c2", 64'(mem_we[0]), 64'd0); adv();
    smp(); chk("t4_ack", 64'({d_rvalid[0], mem_we[0], d_rdata[0]}), 64'({1'b1, 1'b0, last_d})); adv();
    d_req[0] = 1'b1; d_addr[0] = 10'h3FF;
    smp(); chk("t4_load_gnt", 64'(d_gnt[0]), 64'd1);
    last_d = 32'hDEADBEEF; push(0, 1'b1, last_d); adv(); d_req[0] = 1'b0;
    wait_drain(10);

    // MEM_LAT=3: flush during WAIT drops the fetch response
    if_req[1] = 1'b1; if_addr[1] = 10'd5;
    smp(); chk("t5_gnt", 64'(if_gnt[1]), 64'd1); adv(); if_req[1] = 1'b0;
    nrv = 0;
    for (int c = 1; c <= 6; c++) begin
      flush[1] = (c == 2);
      smp();
      if (if_rvalid[1]) nrv++;
      if (c == 5) chk("t5_busy_resp", 64'(busy[1]), 64'd1);
      if (c == 6) chk("t5_busy_idle", 64'(busy[1]), 64'd0);
      adv();
    end
    flush[1] = 1'b0;
    chk("t5_no_if_rvalid", 64'(nrv), 64'd0);
    if_req[1] = 1'b1; if_addr[1] = 10'd5;
    smp(); chk("t5_gnt2", 64'(if_gnt[1]), 64'd1); push(1, 1'b0, 32'h2842000A); adv(); if_req[1] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      smp();
      if (c == 5) chk("t5_if_rvalid_c5", 64'(if_rvalid[1]), 64'd1);
      adv();
    end

    // asynchronous reset in WAIT
    if_req[1] = 1'b1; if_addr[1] = 10'd6;
    smp(); chk("t6_gnt", 64'(if_gnt[1]), 64'd1); adv(); if_req[1] = 1'b0;
    smp(); adv();
    #1 rst[1] = 1'b1;
    #1 chk("t6_async_reset", 64'({busy[1], mem_en[1], if_rvalid[1], d_rvalid[1], mem_addr[1], if_rdata[1]}), 64'd0);
    smp(); adv();
    rst[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      smp(); chk("t6_no_rvalid", 64'({if_rvalid[1], d_rvalid[1]}), 64'd0); adv();
    end
    if_req[1] = 1'b1; if_addr[1] = 10'd8;
    smp(); chk("t6_gnt2", 64'(if_gnt[1]), 64'd1); push(1, 1'b0, dflt_word(10'd8)); adv(); if_req[1] = 1'b0;
    wait_drain(12);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
